// File: rtl/shift_reg_univ.sv
// Universal WIDTH-bit register: load, logical/arithmetic shifts, rotates, clear,
// plus a saturating count of shifts since the last load/clear/reset.
module shift_reg_univ #(
   parameter int                 WIDTH     = 8,
   parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}},
   parameter int                 CNT_W     = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             sin_l,
   input  logic             sin_r,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_bar,
   output logic             sout_l,
   output logic             sout_r,
   output logic             zero,
   output logic [CNT_W-1:0] shift_cnt
);

   typedef enum logic [2:0] {
      M_HOLD = 3'b000,
      M_LOAD = 3'b001,
      M_SHL  = 3'b010,
      M_SHR  = 3'b011,
      M_ROL  = 3'b100,
      M_ROR  = 3'b101,
      M_ASR  = 3'b110,
      M_CLR  = 3'b111
   } mode_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   mode_t            op;
   logic [WIDTH-1:0] q_nxt;
   logic             is_shift;
   logic             cnt_clr;

   assign op = mode_t'(mode);

   always_comb begin
      q_nxt    = q;
      is_shift = 1'b0;
      cnt_clr  = 1'b0;
      unique case (op)
         M_HOLD: q_nxt = q;
         M_LOAD: begin q_nxt = d; cnt_clr = 1'b1; end
         M_SHL:  begin q_nxt = {q[WIDTH-2:0], sin_r};      is_shift = 1'b1; end
         M_SHR:  begin q_nxt = {sin_l, q[WIDTH-1:1]};      is_shift = 1'b1; end
         M_ROL:  begin q_nxt = {q[WIDTH-2:0], q[WIDTH-1]}; is_shift = 1'b1; end
         M_ROR:  begin q_nxt = {q[0], q[WIDTH-1:1]};       is_shift = 1'b1; end
         M_ASR:  begin q_nxt = {q[WIDTH-1], q[WIDTH-1:1]}; is_shift = 1'b1; end
         M_CLR:  begin q_nxt = '0; cnt_clr = 1'b1; end
         default: q_nxt = q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         q         <= RESET_VAL;
         shift_cnt <= '0;
      end else if (en) begin
         q <= q_nxt;
         if (cnt_clr)
            shift_cnt <= '0;
         else if (is_shift && shift_cnt != CNT_MAX)
            shift_cnt <= shift_cnt + 1'b1;
      end
   end

   // Derived outputs are combinational views of q, valid in the same cycle.
   assign q_bar  = ~q;
   assign sout_l = q[WIDTH-1];
   assign sout_r = q[0];
   assign zero   = (q == '0);

endmodule
